miss_gap_tracker: RTL
=====================

Name: miss_gap_tracker

Overview:
- Multi-channel successor to the single-feed MoldUDP64 missed-message detector.
- Tracks the expected session id (sid) and sequence number per channel for CH_N interleaved feeds.
- Classifies each packet header as in-order, gap, stale/duplicate, or session skip.
- Converts sequence gaps into retransmission requests no larger than MAX_REQ messages, buffered in a request FIFO with a valid/ready handshake. Sits between the packet header parser and the retransmission request builder.

Parameters:
- SEQ_NUM_W, 64, sequence number width.
- SID_W, 80, session id width.
- ML_W, 16, message count width.
- CH_N, 2, number of tracked channels.
- CH_W, $clog2(CH_N) (min 1), channel index width.
- REQ_DEPTH, 8, request FIFO depth (power of 2).
- MAX_REQ, 16'hFFFF, maximum message count per request (>0).
- SEQ_INIT, 1, first sequence number of a session.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- v_i  in  1  header valid.
- ready_o  out  1  header accepted when v_i & ready_o.
- ch_i  in  CH_W  channel index.
- sid_i  in  SID_W  session id.
- seq_num_i  in  SEQ_NUM_W  first sequence number in packet.
- msg_cnt_i  in  ML_W  message count.
- eos_i  in  1  end of session.
- req_v_o  out  1  request valid.
- req_ready_i  in  1  request consumed.
- req_ch_o  out  CH_W  request channel.
- req_sid_o  out  SID_W  request session.
- req_seq_o  out  SEQ_NUM_W  first missing sequence number.
- req_cnt_o  out  ML_W  missing count, 1..MAX_REQ.
- sid_skip_v_o  out  1  one-cycle session skip pulse.
- sid_skip_ch_o  out  CH_W  channel.
- sid_skip_start_o  out  SID_W  first affected sid.
- sid_skip_cnt_o  out  SID_W  number of affected sessions.
- sid_skip_seq_o  out  SEQ_NUM_W  resume sequence number within sid_skip_start_o.
- dup_cnt_o  out  32  stale/duplicate packet count, saturating.

Behaviour:
- Reset:
  - All channels unlocked; FIFO empty.
  - req_v_o=0, sid_skip_v_o=0, dup_cnt_o=0, FSM=IDLE.
  - ready_o=0 while reset is high, 1 from the first cycle after release.
  - Reset mid-split abandons the remaining gap.
- Per-channel state: locked, sid_q, seq_q (next expected), eos_q.
- ready_o = (FSM==IDLE) & (fifo_cnt < REQ_DEPTH). A header with ch_i >= CH_N is accepted and ignored.
- On accept, channel c:
  - Unlocked: lock; sid_q=sid_i; seq_q=seq_num_i+msg_cnt_i. No report.
  - sid_i==sid_q, seq_num_i==seq_q: seq_q += msg_cnt_i.
  - sid_i==sid_q, seq_num_i>seq_q: gap G=seq_num_i-seq_q. Enter SPLIT with base=seq_q. Then seq_q=seq_num_i+msg_cnt_i.
  - sid_i==sid_q, seq_num_i<seq_q: stale. dup_cnt_o++. seq_q=max(seq_q, seq_num_i+msg_cnt_i).
  - sid_i==sid_q+1 with eos_q set: clean rollover; the sid_i==sid_q rules apply with seq_q=SEQ_INIT.
  - Any other sid_i>sid_q: sid_skip_v_o pulses the next cycle.
    - eos_q set: start=sid_q+1, cnt=sid_i-sid_q-1.
    - eos_q clear: start=sid_q, cnt=sid_i-sid_q, seq=seq_q.
    - Relock to sid_i with seq_q=seq_num_i+msg_cnt_i. No sequence request is issued across sessions.
  - sid_i<sid_q: stale; dup_cnt_o++; no state change.
  - eos_i sets eos_q. Any other accepted packet on the channel clears it. An eos packet still performs the gap check (it carries the next sequence number).
- FSM:
  - IDLE: a gap moves to SPLIT.
  - SPLIT: each cycle with FIFO space, push {c, sid, base, min(rem, MAX_REQ)}; base += pushed; rem -= pushed. Return to IDLE after the push where rem reaches 0.
  - One push costs 0 extra cycles: the gap packet cycle pushes directly. Each further chunk adds one cycle of ready_o=0.
- Gap length and rem are SEQ_NUM_W wide. Arithmetic is unsigned modulo 2^SEQ_NUM_W; wrap is not treated specially.
- FIFO:
  - Show-ahead; a request is visible on req_* the cycle after its push.
  - Simultaneous push and pop is allowed when not full.
  - Outputs hold stable while req_v_o & !req_ready_i.

Decomposition:
- Package moldudp64_pkg:
  - Constants SEQ_NUM_W, SID_W, ML_W.
  - typedef miss_req_t {ch, sid, seq, cnt}.
  - typedef ch_state_t {locked, eos, sid, seq}.
- Sub-module miss_req_fifo: synchronous show-ahead FIFO of miss_req_t, parametrised on DEPTH, exposing count.

Test Plan:
- ch0 sid=5: seq=1 cnt=3, then seq=4 cnt=2 -> no req; seq_q=6; ready_o stays 1.
- ch0 sid=5, seq=10 cnt=2 (expected 6) -> one req {ch0, 5, 6, 4}; seq_q=12.
- MAX_REQ=100, ch0 gap of 250 at base 12 -> reqs (12,100), (112,100), (212,50) on consecutive cycles. ready_o low 2 cycles.
- ch0 seq=3 cnt=2 while expected 12 -> no req; dup_cnt_o=1; seq_q unchanged. Then sid=4 -> dup_cnt_o=2.
- ch0 eos at seq=12, then sid=6 seq=1 -> no report. Then sid=8 seq=1 without eos -> skip pulse start=6, cnt=2, seq=2.
- ch1 interleaved with ch0 gaps, req_ready_i=0 until FIFO holds 8 -> ready_o=0, no loss, in-order drain; reset mid-SPLIT -> FIFO empty, channels unlocked.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// Shared widths, payload types and helpers for the multi-channel MoldUDP64 gap tracker.
package moldudp64_pkg;

  localparam int unsigned SEQ_NUM_W = 64;
  localparam int unsigned SID_W     = 80;
  localparam int unsigned ML_W      = 16;
  // Channel count the request payload is sized for; CH_W = max(1, clog2(CH_N_DFLT)).
  localparam int unsigned CH_N_DFLT = 2;
  localparam int unsigned CH_W      = (CH_N_DFLT > 1) ? $clog2(CH_N_DFLT) : 1;

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [SID_W-1:0]     sid;
    logic [SEQ_NUM_W-1:0] seq;
    logic [ML_W-1:0]      cnt;
  } miss_req_t;

  typedef struct packed {
    logic                 locked;
    logic                 eos;
    logic [SID_W-1:0]     sid;
    logic [SEQ_NUM_W-1:0] seq;
  } ch_state_t;

  typedef enum logic {
    IDLE,
    SPLIT
  } fsm_t;

  // Clip a remaining gap length to the per-request message limit.
  function automatic logic [ML_W-1:0] clip_cnt(input logic [SEQ_NUM_W-1:0] len,
                                               input logic [ML_W-1:0]      lim);
    return (len > SEQ_NUM_W'(lim)) ? lim : ML_W'(len);
  endfunction

endpackage

// File: rtl/miss_req_fifo.sv
// Show-ahead request FIFO; head entry is visible the cycle after it is pushed.
module miss_req_fifo
  import moldudp64_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  miss_req_t              din,
  input  logic                   pop,
  output miss_req_t              dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  miss_req_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (32'(count) < DEPTH);
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];
  assign valid   = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: valid is derived from count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/miss_gap_tracker.sv
// Per-channel session/sequence tracker that turns sequence gaps into bounded
// retransmission requests and reports session skips and stale packets.
module miss_gap_tracker
  import moldudp64_pkg::*;
#(
  parameter int unsigned          CH_N      = CH_N_DFLT,
  parameter int unsigned          REQ_DEPTH = 8,
  parameter logic [ML_W-1:0]      MAX_REQ   = 16'hFFFF,
  parameter logic [SEQ_NUM_W-1:0] SEQ_INIT  = 64'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v_i,
  output logic                 ready_o,
  input  logic [CH_W-1:0]      ch_i,
  input  logic [SID_W-1:0]     sid_i,
  input  logic [SEQ_NUM_W-1:0] seq_num_i,
  input  logic [ML_W-1:0]      msg_cnt_i,
  input  logic                 eos_i,
  output logic                 req_v_o,
  input  logic                 req_ready_i,
  output logic [CH_W-1:0]      req_ch_o,
  output logic [SID_W-1:0]     req_sid_o,
  output logic [SEQ_NUM_W-1:0] req_seq_o,
  output logic [ML_W-1:0]      req_cnt_o,
  output logic                 sid_skip_v_o,
  output logic [CH_W-1:0]      sid_skip_ch_o,
  output logic [SID_W-1:0]     sid_skip_start_o,
  output logic [SID_W-1:0]     sid_skip_cnt_o,
  output logic [SEQ_NUM_W-1:0] sid_skip_seq_o,
  output logic [31:0]          dup_cnt_o
);

  localparam int unsigned CNT_W = $clog2(REQ_DEPTH) + 1;

  fsm_t                 state;
  ch_state_t            chs [CH_N];
  ch_state_t            cur;
  logic [CNT_W-1:0]     fifo_cnt;
  miss_req_t            push_req;
  miss_req_t            head;
  logic                 push;
  logic                 space;
  logic                 hit;
  logic                 same;
  logic                 roll;
  logic                 in_sess;
  logic                 is_gap;
  logic                 dup_inc;
  logic [SEQ_NUM_W-1:0] exp_seq;
  logic [SEQ_NUM_W-1:0] end_seq;
  logic [SEQ_NUM_W-1:0] gap;
  logic [SEQ_NUM_W-1:0] nxt_seq;
  logic [CH_W-1:0]      sp_ch;
  logic [SID_W-1:0]     sp_sid;
  logic [SEQ_NUM_W-1:0] sp_base;
  logic [SEQ_NUM_W-1:0] sp_rem;
  logic [ML_W-1:0]      sp_chunk;

  assign space   = (32'(fifo_cnt) < REQ_DEPTH);
  assign ready_o = !reset && (state == IDLE) && space;

  // Header classification against the addressed channel's state.
  always_comb begin
    hit = v_i && ready_o && (32'(ch_i) < CH_N);
    cur = '0;
    if (hit) cur = chs[ch_i];
    same     = (sid_i == cur.sid);
    roll     = cur.eos && (sid_i == cur.sid + SID_W'(1));
    in_sess  = cur.locked && (same || roll);
    exp_seq  = roll ? SEQ_INIT : cur.seq;
    end_seq  = seq_num_i + SEQ_NUM_W'(msg_cnt_i);
    gap      = seq_num_i - exp_seq;
    is_gap   = hit && in_sess && (seq_num_i > exp_seq);
    nxt_seq  = ((seq_num_i < exp_seq) && (end_seq < exp_seq)) ? exp_seq : end_seq;
    dup_inc  = hit && cur.locked &&
               (in_sess ? (seq_num_i < exp_seq) : (sid_i < cur.sid));
    sp_chunk = clip_cnt(sp_rem, MAX_REQ);
    push     = 1'b0;
    push_req = '0;
    if (is_gap) begin
      push     = 1'b1;
      push_req = '{ch: ch_i, sid: sid_i, seq: exp_seq, cnt: clip_cnt(gap, MAX_REQ)};
    end else if ((state == SPLIT) && space) begin
      push     = 1'b1;
      push_req = '{ch: sp_ch, sid: sp_sid, seq: sp_base, cnt: sp_chunk};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      chs              <= '{default: '0};
      sid_skip_v_o     <= 1'b0;
      sid_skip_ch_o    <= '0;
      sid_skip_start_o <= '0;
      sid_skip_cnt_o   <= '0;
      sid_skip_seq_o   <= '0;
      dup_cnt_o        <= '0;
      sp_ch            <= '0;
      sp_sid           <= '0;
      sp_base          <= '0;
      sp_rem           <= '0;
    end else begin
      sid_skip_v_o <= 1'b0;
      if (dup_inc && (dup_cnt_o != '1)) dup_cnt_o <= dup_cnt_o + 32'd1;

      if (hit) begin
        if (!cur.locked) begin
          chs[ch_i] <= '{locked: 1'b1, eos: eos_i, sid: sid_i, seq: end_seq};
        end else if (in_sess) begin
          chs[ch_i] <= '{locked: 1'b1, eos: eos_i, sid: sid_i, seq: nxt_seq};
        end else if (sid_i > cur.sid) begin
          // Forward session jump: report skipped sessions and relock.
          chs[ch_i]     <= '{locked: 1'b1, eos: eos_i, sid: sid_i, seq: end_seq};
          sid_skip_v_o  <= 1'b1;
          sid_skip_ch_o <= ch_i;
          if (cur.eos) begin
            sid_skip_start_o <= cur.sid + SID_W'(1);
            sid_skip_cnt_o   <= sid_i - cur.sid - SID_W'(1);
            sid_skip_seq_o   <= SEQ_INIT;
          end else begin
            sid_skip_start_o <= cur.sid;
            sid_skip_cnt_o   <= sid_i - cur.sid;
            sid_skip_seq_o   <= cur.seq;
          end
        end
      end

      // The gap packet cycle pushes the first chunk; SPLIT emits the rest.
      case (state)
        IDLE: begin
          if (is_gap && (gap > SEQ_NUM_W'(MAX_REQ))) begin
            state   <= SPLIT;
            sp_ch   <= ch_i;
            sp_sid  <= sid_i;
            sp_base <= exp_seq + SEQ_NUM_W'(MAX_REQ);
            sp_rem  <= gap - SEQ_NUM_W'(MAX_REQ);
          end
        end
        SPLIT: begin
          if (space) begin
            sp_base <= sp_base + SEQ_NUM_W'(sp_chunk);
            sp_rem  <= sp_rem - SEQ_NUM_W'(sp_chunk);
            if (sp_rem == SEQ_NUM_W'(sp_chunk)) state <= IDLE;
          end
        end
      endcase
    end
  end

  miss_req_fifo #(
    .DEPTH(REQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_req),
    .pop   (req_v_o && req_ready_i),
    .dout  (head),
    .valid (req_v_o),
    .count (fifo_cnt)
  );

  assign req_ch_o  = head.ch;
  assign req_sid_o = head.sid;
  assign req_seq_o = head.seq;
  assign req_cnt_o = head.cnt;

endmodule
